usb_data_buffer: RTL and testbench

USB_DATA_BUFFER -- requirements
Module: usb_data_buffer

---
 rtl/usb_data_buffer.sv | 83 ++++++++
 tb/tb_usb_data_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_buffer.sv
// usb_data_buffer: byte FIFO between the USB RX packet side and the TX/host side.
// Registered read data, occupancy counter, sticky overflow/underflow flags.
module usb_data_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come from registered occupancy only.
    assign full  = (occupancy == (AW+1)'(DEPTH));
    assign empty = (occupancy == '0);

    // Accept decisions use pre-edge flags, so a read cannot free room for
    // a same-cycle write and a write cannot feed a same-cycle read.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (!clear && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, read data and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                occupancy <= occupancy + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                occupancy <= occupancy - 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_data_buffer.sv
// tb_usb_data_buffer: directed self-checking bench for usb_data_buffer.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_usb_data_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic [6:0] occupancy;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    usb_data_buffer #(.DEPTH(64), .WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .occupancy(occupancy),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (occupancy !== 7'd0 || empty !== 1'b1 || full !== 1'b0 ||
            rd_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: occ=%0d empty=%b full=%b rd=%h ov=%b un=%b",
                     occupancy, empty, full, rd_data, overflow, underflow);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        pop();
        checks++;
        if (rd_data !== 8'hC0 || occupancy !== 7'd4) begin
            errors++;
            $display("FAIL pre_reset: rd=%h occ=%0d want C0/4", rd_data, occupancy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (occupancy !== 7'd0 || empty !== 1'b1 || full !== 1'b0 ||
            rd_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: occ=%0d empty=%b full=%b rd=%h want 0/1/0/00",
                     occupancy, empty, full, rd_data);
        end
        #1;
        rst = 1'b0;
        tick();
        push(8'h5A);
        pop();
        checks++;
        if (rd_data !== 8'h5A || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: rd=%h empty=%b want 5A/1", rd_data, empty);
        end
    endtask

    task automatic test_order();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) push(exp[i]);
        checks++;
        if (occupancy !== 7'd3) begin
            errors++;
            $display("FAIL order_occ: occ=%0d want 3", occupancy);
        end
        for (int i = 0; i < 3; i++) begin
            pop();
            checks++;
            if (rd_data !== exp[i]) begin
                errors++;
                $display("FAIL order_rd%0d: rd=%h want %h", i, rd_data, exp[i]);
            end
        end
        tick();
        checks++;
        if (empty !== 1'b1 || rd_data !== 8'h33) begin
            errors++;
            $display("FAIL order_end: empty=%b rd=%h want 1/33", empty, rd_data);
        end
    endtask

    task automatic test_full_wrap();
        int bad = 0;
        do_clear();
        for (int i = 0; i < 64; i++) push(8'(i));
        checks++;
        if (full !== 1'b1 || occupancy !== 7'd64 || empty !== 1'b0 ||
            overflow !== 1'b0) begin
            errors++;
            $display("FAIL full: full=%b occ=%0d empty=%b ov=%b want 1/64/0/0",
                     full, occupancy, empty, overflow);
        end
        push(8'hFF);
        checks++;
        if (overflow !== 1'b1 || occupancy !== 7'd64) begin
            errors++;
            $display("FAIL overflow: ov=%b occ=%0d want 1/64", overflow, occupancy);
        end
        for (int i = 0; i < 64; i++) begin
            pop();
            checks++;
            if (rd_data !== 8'(i)) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL drain%0d: rd=%h want %h", i, rd_data, 8'(i));
            end
        end
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drained: empty=%b ov=%b want 1/1", empty, overflow);
        end
        push(8'hA5);
        pop();
        checks++;
        if (rd_data !== 8'hA5 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap: rd=%h empty=%b want A5/1", rd_data, empty);
        end
    endtask

    task automatic test_simultaneous();
        do_clear();
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h80 + 8'(i);
            tick();
            checks++;
            if (occupancy !== 7'd10 || rd_data !== 8'h40 + 8'(i)) begin
                errors++;
                $display("FAIL both_mid%0d: occ=%0d rd=%h want 10/%h",
                         i, occupancy, rd_data, 8'h40 + 8'(i));
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 54; i++) push(8'(i));
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL both_prefull: full=%b ov=%b want 1/0", full, overflow);
        end
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (occupancy !== 7'd63 || overflow !== 1'b1 || full !== 1'b0 ||
            rd_data !== 8'h44 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL both_full: occ=%0d ov=%b full=%b rd=%h un=%b want 63/1/0/44/0",
                     occupancy, overflow, full, rd_data, underflow);
        end
        do_clear();
        push(8'h77);
        pop();
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (occupancy !== 7'd1 || underflow !== 1'b1 || rd_data !== 8'h77 ||
            empty !== 1'b0) begin
            errors++;
            $display("FAIL both_empty: occ=%0d un=%b rd=%h empty=%b want 1/1/77/0",
                     occupancy, underflow, rd_data, empty);
        end
        pop();
        checks++;
        if (rd_data !== 8'h99 || empty !== 1'b1) begin
            errors++;
            $display("FAIL both_empty_rd: rd=%h empty=%b want 99/1", rd_data, empty);
        end
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < 64; i++) push(8'h10 + 8'(i));
        push(8'hFF);
        for (int i = 0; i < 57; i++) pop();
        checks++;
        if (occupancy !== 7'd7 || overflow !== 1'b1 || rd_data !== 8'h48) begin
            errors++;
            $display("FAIL clear_pre: occ=%0d ov=%b rd=%h want 7/1/48",
                     occupancy, overflow, rd_data);
        end
        clear = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h3C;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (occupancy !== 7'd0 || overflow !== 1'b0 || empty !== 1'b1 ||
            rd_data !== 8'h00 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL clear: occ=%0d ov=%b empty=%b rd=%h un=%b want 0/0/1/00/0",
                     occupancy, overflow, empty, rd_data, underflow);
        end
        push(8'h6B);
        pop();
        checks++;
        if (rd_data !== 8'h6B || empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_after: rd=%h empty=%b want 6B/1", rd_data, empty);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_wrap();
        test_simultaneous();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
